// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: data width, ALU opcodes,
// forwarding-select encoding and bubble constants.
package id_ex_operand_stage_pkg;

    localparam int unsigned WORD = 32;

    localparam logic [3:0] ADD   = 4'd0;
    localparam logic [3:0] SUB   = 4'd1;
    localparam logic [3:0] AND   = 4'd2;
    localparam logic [3:0] OR    = 4'd3;
    localparam logic [3:0] XOR   = 4'd4;
    localparam logic [3:0] NOR   = 4'd5;
    localparam logic [3:0] SLT   = 4'd6;
    localparam logic [3:0] SHL   = 4'd7;
    localparam logic [3:0] SHR   = 4'd8;
    localparam logic [3:0] SHRA  = 4'd9;
    localparam logic [3:0] NO_OP = 4'hF;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_e;

    localparam logic [3:0] BUBBLE_ALU_OP = NO_OP;
    localparam logic       BUBBLE_VALID  = 1'b0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Bypass select for one source register: EX/MEM beats MEM/WB beats register-file data.
module id_ex_operand_stage_fwd_select
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] src_i,
    input  logic [WORD-1:0] rf_data_i,
    input  logic            exm_reg_write_i,
    input  logic            exm_mem_read_i,
    input  logic [RA_W-1:0] exm_dest_i,
    input  logic [WORD-1:0] exm_result_i,
    input  logic            mwb_reg_write_i,
    input  logic [RA_W-1:0] mwb_dest_i,
    input  logic [WORD-1:0] mwb_data_i,
    output fwd_sel_e        sel_o,
    output logic [WORD-1:0] data_o
);

    always_comb begin
        sel_o  = FWD_REG;
        data_o = rf_data_i;
        // r0 is hardwired, so a pending write to it must never win
        if (src_i != '0) begin
            if (exm_reg_write_i && !exm_mem_read_i && exm_dest_i == src_i) begin
                sel_o  = FWD_EXM;
                data_o = exm_result_i;
            end else if (mwb_reg_write_i && mwb_dest_i == src_i) begin
                sel_o  = FWD_MWB;
                data_o = mwb_data_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypass, hazard stall and saturating stall counter.
// Define FORWARD_EN to enable the EX/MEM and MEM/WB bypass paths (else stall on any RAW).
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned RA_W   = 5,
    parameter int unsigned SCNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [RA_W-1:0]   id_rs_i,
    input  logic [RA_W-1:0]   id_rt_i,
    input  logic [RA_W-1:0]   id_dest_i,
    input  logic [WORD-1:0]   id_rs_data_i,
    input  logic [WORD-1:0]   id_rt_data_i,
    input  logic [WORD-1:0]   id_imm_i,
    input  logic              id_use_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic              id_use_shamt_i,
    input  logic [3:0]        id_alu_op_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              exm_reg_write_i,
    input  logic              exm_mem_read_i,
    input  logic [RA_W-1:0]   exm_dest_i,
    input  logic [WORD-1:0]   exm_result_i,
    input  logic              mwb_reg_write_i,
    input  logic [RA_W-1:0]   mwb_dest_i,
    input  logic [WORD-1:0]   mwb_data_i,
    output logic [WORD-1:0]   ex_data1_o,
    output logic [WORD-1:0]   ex_data2_o,
    output logic [3:0]        ex_alu_op_o,
    output logic [WORD-1:0]   ex_store_data_o,
    output logic [RA_W-1:0]   ex_dest_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_valid_o,
    output logic              stall_id_o,
    output logic [SCNT_W-1:0] stall_count_o
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            use_imm;
        logic            use_shamt;
        logic [3:0]      alu_op;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] dest;
        logic [4:0]      shamt;
        logic [WORD-1:0] rs_data;
        logic [WORD-1:0] rt_data;
        logic [WORD-1:0] imm;
    } id_ex_t;

    localparam id_ex_t IdExBubble = '{valid: BUBBLE_VALID, alu_op: BUBBLE_ALU_OP, default: '0};

    id_ex_t            id_ex_q, id_ex_d;
    logic [SCNT_W-1:0] stall_count_q, stall_count_d;
    logic              hazard;
    logic              load_bubble;
    logic [WORD-1:0]   rs_fwd, rt_fwd;

`ifdef FORWARD_EN
    fwd_sel_e rs_sel, rt_sel;
    logic     unused_sel;

    assign hazard = id_ex_q.valid && id_ex_q.mem_read && id_ex_q.dest != '0 &&
                    (id_ex_q.dest == id_rs_i || (id_ex_q.dest == id_rt_i && !id_use_imm_i));

    id_ex_operand_stage_fwd_select #(.RA_W(RA_W)) u_fwd_rs (
        .src_i           (id_ex_q.rs),
        .rf_data_i       (id_ex_q.rs_data),
        .exm_reg_write_i (exm_reg_write_i),
        .exm_mem_read_i  (exm_mem_read_i),
        .exm_dest_i      (exm_dest_i),
        .exm_result_i    (exm_result_i),
        .mwb_reg_write_i (mwb_reg_write_i),
        .mwb_dest_i      (mwb_dest_i),
        .mwb_data_i      (mwb_data_i),
        .sel_o           (rs_sel),
        .data_o          (rs_fwd)
    );

    id_ex_operand_stage_fwd_select #(.RA_W(RA_W)) u_fwd_rt (
        .src_i           (id_ex_q.rt),
        .rf_data_i       (id_ex_q.rt_data),
        .exm_reg_write_i (exm_reg_write_i),
        .exm_mem_read_i  (exm_mem_read_i),
        .exm_dest_i      (exm_dest_i),
        .exm_result_i    (exm_result_i),
        .mwb_reg_write_i (mwb_reg_write_i),
        .mwb_dest_i      (mwb_dest_i),
        .mwb_data_i      (mwb_data_i),
        .sel_o           (rt_sel),
        .data_o          (rt_fwd)
    );

    assign unused_sel = ^{rs_sel, rt_sel};

    // A load result is not available in EX/MEM; the load-use stall must have prevented this.
    a_no_exm_load_fwd: assert property (@(posedge clk_i) disable iff (rst_i)
        !(id_ex_q.valid && exm_reg_write_i && exm_mem_read_i && exm_dest_i != '0 &&
          ((exm_dest_i == id_ex_q.rs && !id_ex_q.use_shamt) ||
           (exm_dest_i == id_ex_q.rt && !id_ex_q.use_imm))));
`else
    logic raw_rs, raw_rt;
    logic unused_fwd;

    assign raw_rs = (id_rs_i != '0) &&
                    ((id_ex_q.valid && id_ex_q.reg_write && id_ex_q.dest == id_rs_i) ||
                     (exm_reg_write_i && exm_dest_i == id_rs_i) ||
                     (mwb_reg_write_i && mwb_dest_i == id_rs_i));
    assign raw_rt = (id_rt_i != '0) &&
                    ((id_ex_q.valid && id_ex_q.reg_write && id_ex_q.dest == id_rt_i) ||
                     (exm_reg_write_i && exm_dest_i == id_rt_i) ||
                     (mwb_reg_write_i && mwb_dest_i == id_rt_i));
    assign hazard = raw_rs || raw_rt;
    assign rs_fwd = id_ex_q.rs_data;
    assign rt_fwd = id_ex_q.rt_data;
    assign unused_fwd = ^{exm_result_i, mwb_data_i, exm_mem_read_i, id_ex_q.rs, id_ex_q.rt};
`endif

    assign stall_id_o  = hazard && id_valid_i && !flush_i;
    assign load_bubble = flush_i || stall_id_o || !id_valid_i;

    always_comb begin
        id_ex_d = IdExBubble;
        if (!load_bubble) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.reg_write = id_reg_write_i;
            id_ex_d.mem_read  = id_mem_read_i;
            id_ex_d.mem_write = id_mem_write_i;
            id_ex_d.use_imm   = id_use_imm_i;
            id_ex_d.use_shamt = id_use_shamt_i;
            id_ex_d.alu_op    = id_alu_op_i;
            id_ex_d.rs        = id_rs_i;
            id_ex_d.rt        = id_rt_i;
            id_ex_d.dest      = id_dest_i;
            id_ex_d.shamt     = id_shamt_i;
            id_ex_d.rs_data   = id_rs_data_i;
            id_ex_d.rt_data   = id_rt_data_i;
            id_ex_d.imm       = id_imm_i;
        end
        stall_count_d = stall_count_q;
        if (stall_id_o && stall_count_q != '1) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex_q       <= IdExBubble;
            stall_count_q <= '0;
        end else begin
            id_ex_q       <= id_ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_data1_o      = id_ex_q.use_shamt ? {{(WORD-5){1'b0}}, id_ex_q.shamt} : rs_fwd;
    assign ex_data2_o      = id_ex_q.use_imm ? id_ex_q.imm : rt_fwd;
    assign ex_store_data_o = rt_fwd;
    assign ex_alu_op_o     = id_ex_q.alu_op;
    assign ex_dest_o       = id_ex_q.dest;
    assign ex_reg_write_o  = id_ex_q.reg_write;
    assign ex_mem_read_o   = id_ex_q.mem_read;
    assign ex_mem_write_o  = id_ex_q.mem_write;
    assign ex_valid_o      = id_ex_q.valid;
    assign stall_count_o   = stall_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomised bench for id_ex_operand_stage with a behavioural pipeline model and directed pins.
module tb_id_ex_operand_stage;

    localparam int unsigned SW   = 4;
    localparam int unsigned CMAX = 15;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_use_imm, id_use_shamt;
    logic [4:0]  id_rs, id_rt, id_dest, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exm_reg_write, exm_mem_read, mwb_reg_write;
    logic [4:0]  exm_dest, mwb_dest;
    logic [31:0] exm_result, mwb_data;
    logic [31:0] ex_data1, ex_data2, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, stall_id;
    logic [SW-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic auto_pipe = 1'b0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.RA_W(5), .SCNT_W(SW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_dest_i(id_dest),
        .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
        .id_use_imm_i(id_use_imm), .id_shamt_i(id_shamt), .id_use_shamt_i(id_use_shamt),
        .id_alu_op_i(id_alu_op), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
        .id_mem_write_i(id_mem_write), .exm_reg_write_i(exm_reg_write),
        .exm_mem_read_i(exm_mem_read), .exm_dest_i(exm_dest), .exm_result_i(exm_result),
        .mwb_reg_write_i(mwb_reg_write), .mwb_dest_i(mwb_dest), .mwb_data_i(mwb_data),
        .ex_data1_o(ex_data1), .ex_data2_o(ex_data2), .ex_alu_op_o(ex_alu_op),
        .ex_store_data_o(ex_store_data), .ex_dest_o(ex_dest), .ex_reg_write_o(ex_reg_write),
        .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write), .ex_valid_o(ex_valid),
        .stall_id_o(stall_id), .stall_count_o(stall_count)
    );

    // Instruction currently held in EX, as the model believes it to be.
    typedef struct packed {
        logic v, rw, mr, mw, ui, us;
        logic [3:0] op;
        logic [4:0] rs, rt, dest, shamt;
        logic [31:0] rsd, rtd, imm;
    } ex_t;

    ex_t m_ex;
    int  m_cnt = 0;

    function automatic ex_t bubble();
        ex_t b = '0;
        b.op = 4'hF;
        return b;
    endfunction

    // Value the ALU must see for a source register given what sits in the later stages.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
`ifdef FORWARD_EN
        if (src == 5'd0) return rf;
        if (exm_reg_write && !exm_mem_read && exm_dest == src) return exm_result;
        if (mwb_reg_write && mwb_dest == src) return mwb_data;
`endif
        return rf;
    endfunction

    function automatic logic raw(input logic [4:0] src);
        return src != 5'd0 && ((m_ex.v && m_ex.rw && m_ex.dest == src) ||
                               (exm_reg_write && exm_dest == src) ||
                               (mwb_reg_write && mwb_dest == src));
    endfunction

    function automatic logic exp_stall();
        logic hz;
`ifdef FORWARD_EN
        hz = m_ex.v && m_ex.mr && m_ex.dest != 5'd0 &&
             (m_ex.dest == id_rs || (m_ex.dest == id_rt && !id_use_imm));
`else
        hz = raw(id_rs) || raw(id_rt);
`endif
        return hz && id_valid && !flush;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_id", {31'b0, stall_id}, {31'b0, exp_stall()});
            chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_ex.v});
            chk("ex_alu_op", {28'b0, ex_alu_op}, {28'b0, m_ex.op});
            chk("ex_dest", {27'b0, ex_dest}, {27'b0, m_ex.dest});
            chk("ex_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write},
                {29'b0, m_ex.rw, m_ex.mr, m_ex.mw});
            chk("stall_count", {28'b0, stall_count}, m_cnt);
            if (m_ex.v) begin
                chk("ex_data1", ex_data1, m_ex.us ? {27'b0, m_ex.shamt} : fwd(m_ex.rs, m_ex.rsd));
                chk("ex_data2", ex_data2, m_ex.ui ? m_ex.imm : fwd(m_ex.rt, m_ex.rtd));
                chk("ex_store_data", ex_store_data, fwd(m_ex.rt, m_ex.rtd));
            end
        end
    end

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        ex_t old_ex;
        logic st;
        @(posedge clk);
        #1;
        st = exp_stall();
        old_ex = m_ex;
        if (rst) begin
            m_ex = bubble();
            m_cnt = 0;
        end else begin
            if (st && m_cnt < CMAX) m_cnt++;
            if (flush || st || !id_valid) m_ex = bubble();
            else m_ex = '{1'b1, id_reg_write, id_mem_read, id_mem_write, id_use_imm, id_use_shamt,
                          id_alu_op, id_rs, id_rt, id_dest, id_shamt, id_rs_data, id_rt_data, id_imm};
        end
        if (auto_pipe) begin
            mwb_reg_write = rst ? 1'b0 : exm_reg_write;
            mwb_dest      = exm_dest;
            mwb_data      = exm_result;
            exm_reg_write = !rst && old_ex.v && old_ex.rw;
            exm_mem_read  = !rst && old_ex.v && old_ex.mr;
            exm_dest      = old_ex.dest;
            exm_result    = $urandom;
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dest, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic ui, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = 32'h4; id_use_imm = ui;
        id_shamt = 5'd0; id_use_shamt = 1'b0; id_alu_op = 4'd0;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0; flush = 1'b0;
    endtask

    task automatic set_exm(input logic rw, input logic mr, input logic [4:0] d,
                           input logic [31:0] r);
        exm_reg_write = rw; exm_mem_read = mr; exm_dest = d; exm_result = r;
    endtask

    task automatic set_mwb(input logic rw, input logic [4:0] d, input logic [31:0] r);
        mwb_reg_write = rw; mwb_dest = d; mwb_data = r;
    endtask

    task automatic rand_id();
        id_valid     = $urandom_range(99) < 85;
        flush        = $urandom_range(99) < 8;
        rst          = $urandom_range(199) == 0;
        id_rs        = 5'($urandom_range(7));
        id_rt        = 5'($urandom_range(7));
        id_dest      = 5'($urandom_range(7));
        id_rs_data   = $urandom;
        id_rt_data   = $urandom;
        id_imm       = $urandom;
        id_use_imm   = $urandom_range(9) < 3;
        id_shamt     = 5'($urandom_range(31));
        id_use_shamt = $urandom_range(9) < 2;
        id_alu_op    = 4'($urandom_range(9));
        id_mem_read  = $urandom_range(3) == 0;
        id_reg_write = id_mem_read || ($urandom_range(1) == 1);
        id_mem_write = !id_mem_read && ($urandom_range(9) == 0);
    endtask

    initial begin
        m_ex = bubble();
        rst = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_exm(1'b0, 1'b0, 5'd0, 32'd0);
        set_mwb(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("reset_alu_op", {28'b0, ex_alu_op}, 32'hF);
        chk("reset_stall_count", {28'b0, stall_count}, 32'd0);
        chk("reset_stall_id", {31'b0, stall_id}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
`ifdef FORWARD_EN
        // ADD r4,r3,r5 with producer of r3 now in EX/MEM
        set_id(1'b1, 5'd3, 5'd5, 5'd4, 32'd0, 32'd5, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_exm(1'b1, 1'b0, 5'd3, 32'h10);
        @(negedge clk);
        chk("pin_fwd_exm_data1", ex_data1, 32'h10);
        tick();
        // EX/MEM has priority over MEM/WB for r7
        set_exm(1'b0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd1, 5'd7, 5'd8, 32'd1, 32'h99, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_exm(1'b1, 1'b0, 5'd7, 32'hA);
        set_mwb(1'b1, 5'd7, 32'hB);
        @(negedge clk);
        chk("pin_priority_data2", ex_data2, 32'hA);
        tick();
        // LW r2 then ADD r6,r2,r1
        set_exm(1'b0, 1'b0, 5'd0, 32'd0);
        set_mwb(1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h100, 32'd0, 1'b1, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 5'd1, 5'd6, 32'd0, 32'h100, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pin_loaduse_stall", {31'b0, stall_id}, 32'd1);
        tick();
        set_exm(1'b1, 1'b1, 5'd2, 32'h104);
        @(negedge clk);
        chk("pin_loaduse_bubble", {31'b0, ex_valid}, 32'd0);
        chk("pin_loaduse_nostall", {31'b0, stall_id}, 32'd0);
        chk("pin_loaduse_count", {28'b0, stall_count}, 32'd1);
        tick();
        set_exm(1'b0, 1'b0, 5'd0, 32'd0);
        set_mwb(1'b1, 5'd2, 32'h55);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_loaduse_mwb_data1", ex_data1, 32'h55);
        tick();
        // flush with load-use on the same cycle
        set_mwb(1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h100, 32'd0, 1'b1, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 5'd1, 5'd6, 32'd0, 32'h100, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("pin_flush_nostall", {31'b0, stall_id}, 32'd0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_flush_bubble", {31'b0, ex_valid}, 32'd0);
        chk("pin_flush_count", {28'b0, stall_count}, 32'd1);
        tick();
`else
        // ADD r3 then ADD r4,r3,r5: stall until r3 leaves MEM/WB, no bypass afterwards
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 5'd4, 32'h77, 32'd5, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pin_raw_idex_stall", {31'b0, stall_id}, 32'd1);
        tick();
        set_exm(1'b1, 1'b0, 5'd3, 32'hAA);
        @(negedge clk);
        chk("pin_raw_exm_stall", {31'b0, stall_id}, 32'd1);
        chk("pin_raw_bubble", {31'b0, ex_valid}, 32'd0);
        tick();
        set_exm(1'b0, 1'b0, 5'd0, 32'd0);
        set_mwb(1'b1, 5'd3, 32'hAA);
        @(negedge clk);
        chk("pin_raw_mwb_stall", {31'b0, stall_id}, 32'd1);
        tick();
        set_mwb(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("pin_raw_clear", {31'b0, stall_id}, 32'd0);
        chk("pin_raw_count", {28'b0, stall_count}, 32'd3);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_exm(1'b1, 1'b0, 5'd3, 32'h10);
        @(negedge clk);
        chk("pin_nobypass_data1", ex_data1, 32'h77);
        tick();
        // flush with RAW on the same cycle
        set_exm(1'b0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 5'd4, 32'h77, 32'd5, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("pin_flush_nostall", {31'b0, stall_id}, 32'd0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_flush_bubble", {31'b0, ex_valid}, 32'd0);
        chk("pin_flush_count", {28'b0, stall_count}, 32'd3);
        tick();
`endif
        // a pending write to r0 never forwards or stalls
        set_exm(1'b1, 1'b0, 5'd0, 32'hFF);
        set_mwb(1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd0, 5'd1, 5'd9, 32'd0, 32'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pin_r0_nostall", {31'b0, stall_id}, 32'd0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_r0_data1", ex_data1, 32'd0);
        tick();

        // Randomised phase with EX/MEM and MEM/WB fed from the model's own pipeline.
        set_exm(1'b0, 1'b0, 5'd0, 32'd0);
        set_mwb(1'b0, 5'd0, 32'd0);
        auto_pipe = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rand_id();
            tick();
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
